// File: rtl/grid_pkg.sv
// Shared types and helpers for the 8x8 grid display path.
// The grid is a flat 64-bit word: bit 8*r+c holds row r, column c.
package grid_pkg;

  localparam int GRID_ROWS = 8;
  localparam int GRID_COLS = 8;
  localparam int ROW_W     = $clog2(GRID_ROWS);

  typedef logic [GRID_ROWS*GRID_COLS-1:0] grid_t;
  typedef logic [GRID_COLS-1:0]           row_t;
  typedef logic [GRID_ROWS-1:0]           row_sel_t;
  typedef logic [ROW_W-1:0]               row_idx_t;

  // Extract row r of a grid as a column-drive pattern (bit c = column c).
  function automatic row_t row_of(grid_t g, int r);
    return g[r*GRID_COLS +: GRID_COLS];
  endfunction

endpackage

// File: rtl/grid_display_scan_if.sv
// Signal bundle between the grid producer/controller and the LED scan block.
//   grid       : current generation (producer -> scanner)
//   enable     : 1 = scanning runs, 0 = paused
//   freeze     : 1 = skip frame-boundary capture
//   row_sel    : one-hot row drive, active-high
//   col        : column drive for the selected row, active-high
//   frame_tick : one-cycle pulse on the last cycle of row 7's slot
// master = the side that drives grid/enable/freeze; slave = the scanner.
interface grid_display_scan_if;
  import grid_pkg::*;

  grid_t    grid;
  logic     enable;
  logic     freeze;
  row_sel_t row_sel;
  row_t     col;
  logic     frame_tick;

  modport master (
    output grid, enable, freeze,
    input  row_sel, col, frame_tick
  );

  modport slave (
    input  grid, enable, freeze,
    output row_sel, col, frame_tick
  );

endinterface

// File: rtl/scan_timer.sv
// Row-slot timer for the LED matrix scan.
// Holds the position the next enabled edge will start: slot cycle slot_q
// within row row_q. Each enabled edge consumes that position and advances.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   enable      : advance on this edge
//   row_idx     : row of the position being started
//   slot_start  : position is slot cycle 0
//   blank       : position lies in the leading blanking window
//   frame_last  : position is the final cycle of the last row
module scan_timer
  import grid_pkg::*;
#(
  parameter int DIV   = 1000,
  parameter int BLANK = 16
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     enable,
  output row_idx_t row_idx,
  output logic     slot_start,
  output logic     blank,
  output logic     frame_last
);

  localparam int SLOT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [SLOT_W-1:0] slot_q, slot_d;
  row_idx_t          row_q,  row_d;
  logic              slot_last;

  assign slot_last  = (slot_q == SLOT_W'(DIV - 1));
  assign slot_start = (slot_q == '0);
  assign row_idx    = row_q;
  assign frame_last = slot_last && (row_q == ROW_W'(GRID_ROWS - 1));

  // A zero-length blanking window would make the compare constant.
  if (BLANK > 0) begin : g_blank
    assign blank = (slot_q < SLOT_W'(BLANK));
  end else begin : g_no_blank
    assign blank = 1'b0;
  end

  // NOTE: every always_comb output gets a hold default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    slot_d = slot_q;
    row_d  = row_q;
    if (enable) begin
      if (slot_last) begin
        slot_d = '0;
        row_d  = (row_q == ROW_W'(GRID_ROWS - 1)) ? '0 : row_q + 1'b1;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q <= '0;
      row_q  <= '0;
    end else begin
      slot_q <= slot_d;
      row_q  <= row_d;
    end
  end

endmodule

// File: rtl/grid_display_scan.sv
// Row-multiplexed 8x8 LED matrix driver for the Game-of-Life grid.
// The grid is copied into a frame buffer only as row 0 slot 0 begins, so a
// displayed frame never mixes two generations. The first BLANK cycles of
// every row slot are dark to suppress ghosting.
// Ports:
//   clk    : system clock
//   reset  : asynchronous active-low reset; clears buffer and all outputs
//   bus    : slave side of grid_display_scan_if (grid, enable, freeze in;
//            row_sel, col, frame_tick out, all registered)
module grid_display_scan
  import grid_pkg::*;
#(
  parameter int DIV   = 1000,
  parameter int BLANK = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  grid_display_scan_if.slave    bus
);

  row_idx_t row_idx;
  logic     slot_start;
  logic     blank;
  logic     frame_last;

  scan_timer #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) u_scan_timer (
    .clk        (clk),
    .reset      (reset),
    .enable     (bus.enable),
    .row_idx    (row_idx),
    .slot_start (slot_start),
    .blank      (blank),
    .frame_last (frame_last)
  );

  grid_t    fbuf_q,       fbuf_d;
  row_sel_t row_sel_q,    row_sel_d;
  row_t     col_q,        col_d;
  logic     frame_tick_q, frame_tick_d;
  logic     capture;

  assign capture = bus.enable && slot_start && (row_idx == '0) && !bus.freeze;

  always_comb begin
    fbuf_d       = capture ? bus.grid : fbuf_q;
    row_sel_d    = '0;
    col_d        = '0;
    frame_tick_d = 1'b0;
    if (bus.enable) begin
      frame_tick_d = frame_last;
      if (!blank) begin
        row_sel_d = row_sel_t'(1) << row_idx;
        // Decode from fbuf_d so row 0 shows a grid captured on this same edge.
        col_d     = row_of(fbuf_d, int'(row_idx));
      end
    end
  end

  // NOTE: the frame buffer is reset deliberately, so a reset mid-frame can never flash stale content.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fbuf_q       <= '0;
      row_sel_q    <= '0;
      col_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      fbuf_q       <= fbuf_d;
      row_sel_q    <= row_sel_d;
      col_q        <= col_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.row_sel    = row_sel_q;
  assign bus.col        = col_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_grid_display_scan.sv
// Self-checking bench for grid_display_scan with DIV=10, BLANK=2.
// A reference model derives outputs from the count of enabled edges since
// reset; a negedge process compares it with the DUT every cycle, and the
// directed sequence adds literal expectations at known edges.
module tb_grid_display_scan;
  import grid_pkg::*;

  localparam int DIV   = 10;
  localparam int BLANK = 2;
  localparam int FRAME = GRID_ROWS * DIV;

  localparam logic [63:0] DIAG = 64'h8040201008040201;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] PATT = 64'h0123_4567_89AB_CDEF;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   cur;

  grid_display_scan_if bus ();

  grid_display_scan #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int unsigned m_pos;
  int          m_r;
  int          m_s;
  logic [63:0] m_fbuf;
  logic [7:0]  exp_row_sel;
  logic [7:0]  exp_col;
  logic        exp_tick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos       = 0;
      m_fbuf      = '0;
      exp_row_sel = '0;
      exp_col     = '0;
      exp_tick    = 1'b0;
    end else if (bus.enable) begin
      m_r = (m_pos / DIV) % GRID_ROWS;
      m_s = m_pos % DIV;
      if (m_r == 0 && m_s == 0 && !bus.freeze) m_fbuf = bus.grid;
      if (m_s >= BLANK) begin
        exp_row_sel = 8'(1 << m_r);
        exp_col     = m_fbuf[8*m_r +: 8];
      end else begin
        exp_row_sel = '0;
        exp_col     = '0;
      end
      exp_tick = ((m_pos % FRAME) == FRAME - 1);
      m_pos++;
    end else begin
      exp_row_sel = '0;
      exp_col     = '0;
      exp_tick    = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("model_row_sel", 64'(bus.row_sel), 64'(exp_row_sel));
    check("model_col", 64'(bus.col), 64'(exp_col));
    check("model_frame_tick", 64'(bus.frame_tick), 64'(exp_tick));
    // At most one row may ever be driven.
    check("row_sel_onehot0", 64'($countones(bus.row_sel) <= 1), 64'(1));
  end

  // ---------------- directed helpers ----------------
  task automatic at_edge(input int k);
    while (cur < k) begin
      @(negedge clk);
      cur++;
    end
  endtask

  task automatic expect_out(input string name, input logic [7:0] rs, input logic [7:0] c);
    check({name, "_row_sel"}, 64'(bus.row_sel), 64'(rs));
    check({name, "_col"}, 64'(bus.col), 64'(c));
  endtask

  task automatic expect_tick(input string name, input logic t);
    check(name, 64'(bus.frame_tick), 64'(t));
  endtask

  // Scenario 1 checks, reused after the mid-frame reset.
  task automatic startup_checks(input string tag);
    at_edge(1);  expect_out({tag, "_e1"}, 8'h00, 8'h00);
    at_edge(2);  expect_out({tag, "_e2"}, 8'h00, 8'h00);
    at_edge(3);  expect_out({tag, "_e3"}, 8'h01, 8'h01);
    at_edge(13); expect_out({tag, "_e13"}, 8'h02, 8'h02);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    cur        = 0;
    rst_n      = 1'b0;
    bus.grid   = DIAG;
    bus.enable = 1'b1;
    bus.freeze = 1'b0;

    repeat (3) @(negedge clk);
    expect_out("reset_state", 8'h00, 8'h00);
    expect_tick("reset_tick", 1'b0);
    rst_n = 1'b1;
    cur   = 0;

    // Startup and first rows.
    startup_checks("start");

    // Grid change mid-frame must not tear the displayed frame.
    at_edge(24); bus.grid = ONES;
    at_edge(33); expect_out("tear_row3", 8'h08, 8'h08);
    at_edge(73); expect_out("tear_row7", 8'h80, 8'h80);
    at_edge(79); expect_tick("tick_e79", 1'b0);
    at_edge(80); expect_tick("tick_e80", 1'b1);
    at_edge(81); expect_tick("tick_e81", 1'b0);
    at_edge(83); expect_out("frame2_row0", 8'h01, 8'hFF);
    at_edge(160); expect_tick("tick_e160", 1'b1);

    // Freeze across the edge-161 boundary keeps the old buffer.
    bus.freeze = 1'b1;
    bus.grid   = PATT;
    at_edge(161); bus.freeze = 1'b0;
    expect_tick("tick_e161", 1'b0);
    at_edge(163); expect_out("freeze_row0", 8'h01, 8'hFF);
    at_edge(173); expect_out("freeze_row1", 8'h02, 8'hFF);
    at_edge(240); expect_tick("tick_e240", 1'b1);
    at_edge(243); expect_out("unfreeze_row0", 8'h01, 8'hEF);
    at_edge(253); expect_out("unfreeze_row1", 8'h02, 8'hCD);

    // Asynchronous reset in the middle of row 5.
    at_edge(295); expect_out("pre_reset_row5", 8'h20, 8'h45);
    #2 rst_n = 1'b0;
    #1;
    expect_out("async_reset", 8'h00, 8'h00);
    expect_tick("async_reset_tick", 1'b0);
    bus.grid = DIAG;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cur   = 0;
    startup_checks("rerun");

    // Pause for 7 cycles starting at edge 45.
    at_edge(44); expect_out("pre_pause_row4", 8'h10, 8'h10);
    bus.enable = 1'b0;
    bus.grid   = ONES;
    for (int i = 0; i < 7; i++) begin
      at_edge(cur + 1);
      expect_out("paused", 8'h00, 8'h00);
      expect_tick("paused_tick", 1'b0);
    end
    bus.enable = 1'b1;
    at_edge(52); expect_out("resume_row4", 8'h10, 8'h10);
    at_edge(60); expect_out("no_recapture_row5", 8'h20, 8'h20);
    at_edge(86); expect_tick("late_tick_e86", 1'b0);
    at_edge(87); expect_tick("late_tick_e87", 1'b1);
    at_edge(88); expect_tick("late_tick_e88", 1'b0);

    // Randomised traffic; the model comparator does the checking.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 3) bus.grid = {$urandom, $urandom};
      bus.freeze = ($urandom_range(0, 3) == 0);
      bus.enable = ($urandom_range(0, 9) != 0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
